md_unit: RTL
============

// Module: md_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with private HI/LO registers.
//   Sits in the E stage beside the ALU. It takes forwarded Rs/Rt operands.
//   It raises busy so the hazard logic can stall D-stage md/mfhi/mflo instructions.
//   It generalises the single-cycle ALU-only datapath with configurable width and latencies.
// PARAMETERS
//   WIDTH        32  operand width; HI and LO are WIDTH bits each
//   MULT_CYCLES  5   busy cycles for mult/multu (and madd/msub family); >=1
//   DIV_CYCLES   10  busy cycles for div/divu; >=1
// PORTS
//   clk      in   1        rising-edge clock
//   reset    in   1        synchronous, active-low: reset==0 at posedge clears the unit
//   start    in   1        op valid this cycle (E-stage instruction is an md op, not flushed)
//   op       in   4        0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB,10 MSUBU
//   A        in   WIDTH    Rs operand (forwarded)
//   B        in   WIDTH    Rt operand (forwarded)
//   busy     out  1        registered; 1 while a mult/div is in flight
//   stall    out  1        comb: busy | (start & op in {1,2,3,4,7..10}); feeds hazard unit
//   hi       out  WIDTH    HI register (mfhi data)
//   lo       out  WIDTH    LO register (mflo data)
// BEHAVIOUR
//   Reset: busy=0, counter=0, hi=0, lo=0, latched operands/op=0. Reset overrides start.
//     Reset mid-operation aborts it and leaves no HI/LO update.
//   Issue: at posedge T with start=1, busy=0, op=mult/div class, the unit latches A, B, op.
//     It loads counter with MULT_CYCLES or DIV_CYCLES. busy=1 from T+1.
//   Count: counter decrements each edge while busy. On the edge where counter goes 1->0,
//     HI/LO are written and busy falls together. The result is visible N cycles after issue.
//   Start while busy: ignored entirely; the hazard unit must never issue while stall=1.
//   MTHI/MTLO: with start=1 and busy=0, hi<=A / lo<=A at the next edge (1 cycle, no busy).
//     Ignored while busy.
//   NOP or unknown op with start=1: no state change.
//   MULT: {hi,lo} <= $signed(A)*$signed(B), 2*WIDTH result. MULTU: unsigned product.
//   DIV: lo<=signed quotient truncated toward zero; hi<=remainder with the sign of the dividend.
//   DIVU: unsigned quotient/remainder.
//   Divide by zero (B==0): counts full DIV_CYCLES, then leaves hi/lo unchanged.
//   DIV with A=MIN_INT and B=-1: lo<=MIN_INT (0x80000000 @32), hi<=0.
//   Result is computed from the latched operands, not from live A/B, so a D/E stall after
//     issue is harmless.
// CONFIGURATION
//   MD_MADD_EN defined: ops 7..10 are supported, taking MULT_CYCLES.
//     MADD/MADDU: {hi,lo} <= {hi,lo} + product (signed/unsigned).
//     MSUB/MSUBU: {hi,lo} <= {hi,lo} - product. All arithmetic is modulo 2^(2*WIDTH).
//     {hi,lo} is sampled at completion.
//   MD_MADD_EN undefined: ops 7..10 are treated as NOP. stall excludes them.
//     No accumulate adder is synthesised.
// TESTING (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
//   MULT A=0xFFFFFFFF B=2 -> busy high 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFE.
//   MULTU A=0xFFFFFFFF B=2 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
//   DIV A=-7 B=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIVU A=7 B=2 -> lo=3 hi=1.
//   MTHI A=0x1234 then DIV B=0 -> hi stays 0x1234, lo stays prior value, busy drops after 10.
//   Issue MULT, drive reset=0 on cycle 3 -> busy=0, hi=lo=0 next edge.
//     A second MULT issued while busy and an MTLO while busy -> both ignored.
//   MD_MADD_EN: hi=0 lo=0xFFFFFFFF, MADDU A=1 B=1 -> hi=1 lo=0.
//     MSUB A=1 B=1 from hi=lo=0 -> hi=lo=0xFFFFFFFF.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_unit : multi-cycle multiply/divide unit with private HI/LO registers   |
// | Optional MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int C_CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CW   = $clog2(C_CMAX + 1);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,  OP_MULT  = 4'd1,  OP_MULTU = 4'd2,  OP_DIV  = 4'd3,
    OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5,  OP_MTLO  = 4'd6,  OP_MADD = 4'd7,
    OP_MADDU = 4'd8,  OP_MSUB  = 4'd9,  OP_MSUBU = 4'd10
  } md_op_e;

  logic             busy_q, busy_d;
  logic [C_CW-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic w_is_mul, w_is_div, w_issue;

`ifdef MD_MADD_EN
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                    (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_issue  = start && !busy_q && (w_is_mul || w_is_div);

  // Results are formed from the latched operands only, so live A/B may change after issue.
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic               w_b_zero, w_div_ovf;

  assign w_prod_s  = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                     $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign w_prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign w_b_zero  = (b_q == '0);
  assign w_div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
  assign w_quo_s   = $signed(a_q) / $signed(b_q);
  assign w_rem_s   = $signed(a_q) % $signed(b_q);
  assign w_quo_u   = a_q / b_q;
  assign w_rem_u   = a_q % b_q;

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] w_acc;
  assign w_acc = {hi_q, lo_q};
`endif

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (busy_q) begin
      cnt_d = cnt_q - C_CW'(1);
      if (cnt_q == C_CW'(1)) begin
        busy_d = 1'b0;
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = w_prod_s;
          OP_MULTU: {hi_d, lo_d} = w_prod_u;
          OP_DIV: begin
            if (w_div_ovf) begin
              lo_d = a_q;
              hi_d = '0;
            end else if (!w_b_zero) begin
              lo_d = w_quo_s;
              hi_d = w_rem_s;
            end
          end
          OP_DIVU: begin
            if (!w_b_zero) begin
              lo_d = w_quo_u;
              hi_d = w_rem_u;
            end
          end
`ifdef MD_MADD_EN
          OP_MADD:  {hi_d, lo_d} = w_acc + w_prod_s;
          OP_MADDU: {hi_d, lo_d} = w_acc + w_prod_u;
          OP_MSUB:  {hi_d, lo_d} = w_acc - w_prod_s;
          OP_MSUBU: {hi_d, lo_d} = w_acc - w_prod_u;
`endif
          default: ;
        endcase
      end
    end else if (w_issue) begin
      busy_d = 1'b1;
      op_d   = op;
      a_d    = A;
      b_d    = B;
      cnt_d  = w_is_div ? C_CW'(DIV_CYCLES) : C_CW'(MULT_CYCLES);
    end else if (start) begin
      if (op == OP_MTHI) hi_d = A;
      if (op == OP_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q || (start && (w_is_mul || w_is_div));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire
